// File: rtl/gf256_div_seq.sv
// Sequential GF(2^8) divider: q = a * b^254 over the AES field, computed with
// seven square-and-multiply steps between a valid/ready input and output handshake.
module gf256_div_seq #(
    parameter logic [7:0] POLY   = 8'h1B,
    parameter logic [7:0] ZERO_Q = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] q,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t     state;
    logic [7:0] acc;
    logic [7:0] sq;
    logic [2:0] cnt;
    logic       zflag;
    logic [7:0] sq_n;
    logic [7:0] acc_next;

    // Shift-and-add field multiply; reduction applied whenever the MSB falls off.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = t[7] ? ({t[6:0], 1'b0} ^ POLY) : {t[6:0], 1'b0};
        end
        return p;
    endfunction

    assign sq_n     = gf_mul(sq, sq);
    assign acc_next = gf_mul(acc, sq_n);
    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            q           <= 8'h00;
            div_by_zero <= 1'b0;
            acc         <= 8'h00;
            sq          <= 8'h00;
            cnt         <= 3'd0;
            zflag       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= a;
                        sq    <= b;
                        zflag <= (b == 8'h00);
                        cnt   <= 3'd0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    // acc accumulates b^2, b^4, ... b^128, i.e. b^254 after seven steps
                    acc <= acc_next;
                    sq  <= sq_n;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd6) begin
                        q           <= zflag ? ZERO_Q : acc_next;
                        div_by_zero <= zflag;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gf256_div_seq.sv
// Bench for gf256_div_seq: directed cases plus randomized divisions checked
// against a polynomial-long-division / inverse-table reference model.
module tb_gf256_div_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] q;
    logic       div_by_zero;

    gf256_div_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_acc = 0;
    int n_out = 0;
    bit started = 0;
    logic [7:0] inv_tab [256];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: carry-less product, then reduction by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] mulmod(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] prod;
        prod = 16'h0;
        for (int i = 0; i < 8; i++)
            if (y[i]) prod = prod ^ (16'(x) << i);
        for (int k = 14; k >= 8; k--)
            if (prod[k]) prod = prod ^ (16'h011B << (k - 8));
        return prod[7:0];
    endfunction

    function automatic logic [7:0] model_q(input logic [7:0] x, input logic [7:0] y);
        return (y == 8'h00) ? 8'h00 : mulmod(x, inv_tab[y]);
    endfunction

    // Monitor: per-cycle comparison of handshake behaviour and results against the model.
    logic [7:0] exp_a, exp_b;
    bit         busy = 0;
    int         acc_edge = 0;
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", int'(in_ready), int'(!busy));
            if (busy) chk("out_valid_latency", int'(out_valid), int'((cyc - acc_edge) >= 7));
            else if (out_valid) chk("spurious_out_valid", 1, 0);
            if (busy && out_valid) begin
                chk("model_q", int'(q), int'(model_q(exp_a, exp_b)));
                chk("model_dbz", int'(div_by_zero), int'(exp_b == 8'h00));
            end
            if (rst) begin
                busy = 0;
            end else begin
                if (busy && out_valid && out_ready) begin
                    busy = 0;
                    n_out++;
                end
                if (in_valid && in_ready) begin
                    busy = 1;
                    acc_edge = cyc + 1;
                    exp_a = a;
                    exp_b = b;
                end
            end
        end
    end

    // Both tasks expect to be entered 1 time unit after a rising edge.
    task automatic send(input logic [7:0] ta, input logic [7:0] tb);
        int n = 0;
        in_valid = 1'b1;
        a = ta;
        b = tb;
        while (!in_ready) begin
            @(posedge clk); #1;
            n++;
            if (n > 50) begin
                chk("send_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        last_acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic recv(input int stall_max, output logic [7:0] rq, output logic rz);
        int n = 0;
        out_ready = 1'b0;
        while (!out_valid) begin
            @(posedge clk); #1;
            n++;
            if (n > 50) begin
                chk("recv_timeout", 0, 1);
                rq = 8'hxx;
                rz = 1'bx;
                return;
            end
        end
        repeat ($urandom_range(stall_max)) begin
            @(posedge clk); #1;
        end
        rq = q;
        rz = div_by_zero;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [7:0] rq, ta, tb;
    logic       rz;
    int         prev, n0;

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; out_ready = 1'b0;
        inv_tab[0] = 8'h00;
        for (int y = 1; y < 256; y++)
            for (int x = 1; x < 256; x++)
                if (mulmod(8'(y), 8'(x)) == 8'h01) inv_tab[y] = 8'(x);

        // Pin the model with hand-computed values.
        chk("pin_inv53", int'(inv_tab[8'h53]), 8'hCA);
        chk("pin_inv02", int'(inv_tab[8'h02]), 8'h8D);
        chk("pin_mul", int'(mulmod(8'h57, 8'h83)), 8'hC1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_q", int'(q), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        rst = 1'b0;
        started = 1;

        // Fixed latency of the first division.
        send(8'h01, 8'h53);
        for (int k = 0; k < 7; k++) begin
            chk("t1_in_ready_busy", int'(in_ready), 0);
            chk("t1_out_valid_early", int'(out_valid), 0);
            @(posedge clk); #1;
        end
        chk("t1_out_valid", int'(out_valid), 1);
        chk("t1_q", int'(q), 8'hCA);
        chk("t1_dbz", int'(div_by_zero), 0);
        recv(0, rq, rz);

        // Back-to-back divisions and 9-cycle issue spacing.
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin ta = 8'hC1; tb = 8'h83; end
                1: begin ta = 8'h57; tb = 8'h01; end
                default: begin ta = 8'h00; tb = 8'h35; end
            endcase
            prev = last_acc;
            send(ta, tb);
            if (i > 0) chk("t2_spacing", last_acc - prev, 9);
            recv(0, rq, rz);
            chk("t2_q", int'(rq), (i == 2) ? 8'h00 : 8'h57);
            chk("t2_dbz", int'(rz), 0);
        end

        // Division by zero, then the flag clears.
        send(8'h42, 8'h00);
        recv(0, rq, rz);
        chk("t3_q_zero", int'(rq), 8'h00);
        chk("t3_dbz_set", int'(rz), 1);
        send(8'h02, 8'h02);
        recv(0, rq, rz);
        chk("t3_q", int'(rq), 8'h01);
        chk("t3_dbz_clear", int'(rz), 0);

        // Backpressure with noise on the input side.
        send(8'h01, 8'h02);
        n0 = 0;
        while (!out_valid && n0 < 50) begin
            @(posedge clk); #1;
            n0++;
        end
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            chk("t4_q_hold", int'(q), 8'h8D);
            chk("t4_out_valid_hold", int'(out_valid), 1);
            chk("t4_in_ready_low", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n0 = n_out;
        out_ready = 1'b1;
        chk("t4_q_release", int'(q), 8'h8D);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("t4_one_handshake", n_out - n0, 1);
        chk("t4_out_valid_drop", int'(out_valid), 0);
        chk("t4_idle", int'(in_ready), 1);

        // Reset in the middle of CALC discards the operation.
        send(8'h01, 8'h53);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_out_valid", int'(out_valid), 0);
        chk("t5_in_ready", int'(in_ready), 1);
        chk("t5_q", int'(q), 8'h00);
        chk("t5_dbz", int'(div_by_zero), 0);
        send(8'h01, 8'h53);
        recv(0, rq, rz);
        chk("t5_q_after", int'(rq), 8'hCA);

        // Every divisor once with a random dividend, then random pairs; random stalls.
        for (int i = 0; i < 1800; i++) begin
            if (i < 256) tb = 8'(i);
            else if (i % 50 == 0) tb = 8'h00;
            else tb = 8'($urandom);
            ta = 8'($urandom);
            send(ta, tb);
            recv(3, rq, rz);
            if (tb == 8'h00) begin
                chk("t6_q_zero", int'(rq), 8'h00);
                chk("t6_dbz_set", int'(rz), 1);
            end else begin
                chk("t6_q_times_b", int'(mulmod(rq, tb)), int'(ta));
                chk("t6_dbz_clear", int'(rz), 0);
            end
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
